// File: rtl/sys_defs.sv
// -----------------------------------------------------------------------------
// sys_defs
// Shared definitions used by the reorder buffer and the commit stage.
//   ROB_ENTRY : one reorder-buffer slot (valid, ready, value, dest_reg, dest_addr)
//   ZERO_REG  : architectural register that is never written
//   robNewEntry() : builds a freshly dispatched entry from a dispatch request
// -----------------------------------------------------------------------------
package sys_defs;

   localparam int REG_W  = 5;
   localparam int ADDR_W = 32;

   localparam logic [REG_W-1:0] ZERO_REG = '0;

   typedef struct packed {
      logic              valid;
      logic              ready;
      logic [63:0]       value;
      logic [REG_W-1:0]  dest_reg;
      logic [ADDR_W-1:0] dest_addr;
   } ROB_ENTRY;

   // A dispatched instruction only brings its destination; its status and
   // result fields always start out as "allocated, not yet complete".
   function automatic ROB_ENTRY robNewEntry(input ROB_ENTRY req);
      ROB_ENTRY e;
      e       = req;
      e.valid = 1'b1;
      e.ready = 1'b0;
      e.value = '0;
      return e;
   endfunction

endpackage

// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
// Circular reorder buffer feeding the commit stage. Allocates one entry per
// cycle at the tail, marks entries complete from the CDB and presents the
// oldest entry for in-order retirement. Flush empties the buffer.
//
// Optional feature macro: ROB_HEAD_BYPASS_EN
//   When defined, a CDB write that targets the valid head entry is forwarded
//   combinationally onto head_entry/head_ready, so it can retire in that cycle.
//
// Ports
//   clock, reset          : rising-edge clock, async active-high reset
//   dispatch_valid/entry  : allocate request and new entry payload
//   dispatch_tag          : tail index handed to the dispatched instruction
//   rob_full/empty/count  : occupancy status (registered)
//   cdb_valid/tag/value   : completion broadcast
//   retire                : commit consumed head_entry this cycle
//   flush                 : discard all entries
//   head_entry/head_ready : oldest entry and its readiness to commit
// -----------------------------------------------------------------------------
module reorder_buffer
   import sys_defs::*;
#(
   parameter int ROB_SIZE = 8,
   parameter int TAG_W    = $clog2(ROB_SIZE)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             dispatch_valid,
   input  ROB_ENTRY         dispatch_entry,
   output logic [TAG_W-1:0] dispatch_tag,
   output logic             rob_full,
   output logic             rob_empty,
   output logic [TAG_W:0]   rob_count,
   input  logic             cdb_valid,
   input  logic [TAG_W-1:0] cdb_tag,
   input  logic [63:0]      cdb_value,
   input  logic             retire,
   input  logic             flush,
   output ROB_ENTRY         head_entry,
   output logic             head_ready
);

   ROB_ENTRY         entries_q [ROB_SIZE];
   logic [TAG_W-1:0] head_q;
   logic [TAG_W-1:0] tail_q;
   logic [TAG_W:0]   count_q;
   logic [TAG_W:0]   count_d;

   logic     dispatchAccept;
   logic     retireAccept;
   logic     cdbHit;
   ROB_ENTRY headView;

   assign dispatch_tag = tail_q;
   assign rob_count    = count_q;
   assign rob_full     = (count_q == (TAG_W+1)'(ROB_SIZE));
   assign rob_empty    = (count_q == '0);

   // Full is the registered value, so a retire in the same cycle cannot
   // make room for a dispatch.
   assign dispatchAccept = dispatch_valid && !rob_full;
   assign cdbHit         = cdb_valid && entries_q[cdb_tag].valid;
   assign retireAccept   = retire && head_ready;

   // Head read. Retired and flushed slots are cleared, so an empty buffer
   // naturally shows valid = 0 here.
   always_comb begin
      headView = entries_q[head_q];
`ifdef ROB_HEAD_BYPASS_EN
      if (cdb_valid && (cdb_tag == head_q) && entries_q[head_q].valid) begin
         headView.ready = 1'b1;
         headView.value = cdb_value;
      end
`endif
   end

   assign head_entry = headView;
   assign head_ready = headView.valid && headView.ready;

   // Occupancy: a simultaneous dispatch and retire cancel out.
   always_comb begin
      count_d = count_q;
      if (dispatchAccept && !retireAccept) begin
         count_d = count_q + 1'b1;
      end else if (!dispatchAccept && retireAccept) begin
         count_d = count_q - 1'b1;
      end
   end

   // Array, pointers and count. Flush outranks everything else that cycle.
   // Within the normal path the retire clear is written after the CDB write
   // so a completion landing on the retiring head cannot resurrect the slot.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ROB_SIZE; i++) begin
            entries_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (flush) begin
         for (int i = 0; i < ROB_SIZE; i++) begin
            entries_q[i] <= '0;
         end
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (cdbHit) begin
            entries_q[cdb_tag].value <= cdb_value;
            entries_q[cdb_tag].ready <= 1'b1;
         end
         if (retireAccept) begin
            entries_q[head_q] <= '0;
            head_q            <= head_q + 1'b1;
         end
         if (dispatchAccept) begin
            entries_q[tail_q] <= robNewEntry(dispatch_entry);
            tail_q            <= tail_q + 1'b1;
         end
         count_q <= count_d;
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
// Directed bench for reorder_buffer with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are compared
// 2 units after the edge, well clear of the next active edge.
// -----------------------------------------------------------------------------
module tb_reorder_buffer;
   import sys_defs::*;

   localparam int ROB_SIZE = 8;
   localparam int TAG_W    = 3;

`ifdef ROB_HEAD_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic             clock;
   logic             reset;
   logic             dispatch_valid;
   ROB_ENTRY         dispatch_entry;
   logic [TAG_W-1:0] dispatch_tag;
   logic             rob_full;
   logic             rob_empty;
   logic [TAG_W:0]   rob_count;
   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic [63:0]      cdb_value;
   logic             retire;
   logic             flush;
   ROB_ENTRY         head_entry;
   logic             head_ready;

   int checkCount = 0;
   int failCount  = 0;

   reorder_buffer #(.ROB_SIZE(ROB_SIZE), .TAG_W(TAG_W)) dut (
      .clock          (clock),
      .reset          (reset),
      .dispatch_valid (dispatch_valid),
      .dispatch_entry (dispatch_entry),
      .dispatch_tag   (dispatch_tag),
      .rob_full       (rob_full),
      .rob_empty      (rob_empty),
      .rob_count      (rob_count),
      .cdb_valid      (cdb_valid),
      .cdb_tag        (cdb_tag),
      .cdb_value      (cdb_value),
      .retire         (retire),
      .flush          (flush),
      .head_entry     (head_entry),
      .head_ready     (head_ready)
   );

   // 10-unit clock period
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drives one cycle's worth of inputs and lets combinational paths settle
   task automatic applyStimulus(input logic dv, input logic [4:0] dreg,
                                input logic cv, input logic [TAG_W-1:0] ctag,
                                input logic [63:0] cval, input logic ret,
                                input logic fl);
      ROB_ENTRY e;
      e              = '0;
      e.dest_reg     = dreg;
      e.dest_addr    = 32'h1000 + 32'(dreg);
      e.value        = 64'hDEAD;
      e.ready        = 1'b1;
      dispatch_valid = dv;
      dispatch_entry = e;
      cdb_valid      = cv;
      cdb_tag        = ctag;
      cdb_value      = cval;
      retire         = ret;
      flush          = fl;
      #1;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 5'd0, 1'b0, '0, 64'd0, 1'b0, 1'b0);
   endtask

   task automatic stepCycle();
      @(posedge clock);
      #1;
   endtask

   // Watchdog so the run always ends
   initial begin
      #50000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [TAG_W-1:0] tagOf [22];
      logic [TAG_W-1:0] tailModel;
      logic [63:0]      drainVals [3];

      reset = 1'b1;
      dispatch_valid = 1'b0;
      dispatch_entry = '0;
      cdb_valid = 1'b0;
      cdb_tag = '0;
      cdb_value = '0;
      retire = 1'b0;
      flush = 1'b0;
      #3;

      // ---------------- Reset values ----------------
      checkOutput("rst_empty", 64'(rob_empty), 64'd1);
      checkOutput("rst_full", 64'(rob_full), 64'd0);
      checkOutput("rst_count", 64'(rob_count), 64'd0);
      checkOutput("rst_tag", 64'(dispatch_tag), 64'd0);
      checkOutput("rst_head_ready", 64'(head_ready), 64'd0);
      checkOutput("rst_head_valid", 64'(head_entry.valid), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      stepCycle();

      // ---------------- Fill to capacity ----------------
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 5'(i + 1), 1'b0, '0, 64'd0, 1'b0, 1'b0);
         checkOutput("fill_tag", 64'(dispatch_tag), 64'(i));
         stepCycle();
      end
      idle();
      checkOutput("fill_full", 64'(rob_full), 64'd1);
      checkOutput("fill_count", 64'(rob_count), 64'd8);
      checkOutput("fill_head_valid", 64'(head_entry.valid), 64'd1);
      checkOutput("fill_head_reg", 64'(head_entry.dest_reg), 64'd1);
      checkOutput("fill_head_addr", 64'(head_entry.dest_addr), 64'h1001);
      checkOutput("fill_head_value", head_entry.value, 64'd0);
      checkOutput("fill_head_ready", 64'(head_ready), 64'd0);

      // Ninth dispatch must be dropped
      applyStimulus(1'b1, 5'd9, 1'b0, '0, 64'd0, 1'b0, 1'b0);
      stepCycle();
      idle();
      checkOutput("drop_count", 64'(rob_count), 64'd8);
      checkOutput("drop_tail", 64'(dispatch_tag), 64'd0);
      checkOutput("drop_head_reg", 64'(head_entry.dest_reg), 64'd1);

      // ---------------- Mid-cycle async reset with 3 entries ----------------
      reset = 1'b1;
      #1;
      reset = 1'b0;
      stepCycle();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 5'(i + 1), 1'b0, '0, 64'd0, 1'b0, 1'b0);
         stepCycle();
      end
      idle();
      checkOutput("pre_reset_count", 64'(rob_count), 64'd3);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_empty", 64'(rob_empty), 64'd1);
      checkOutput("async_count", 64'(rob_count), 64'd0);
      checkOutput("async_head_valid", 64'(head_entry.valid), 64'd0);
      checkOutput("async_tag", 64'(dispatch_tag), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      stepCycle();

      // ---------------- Out-of-order completion ----------------
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 5'(i + 1), 1'b0, '0, 64'd0, 1'b0, 1'b0);
         stepCycle();
      end
      applyStimulus(1'b0, 5'd0, 1'b1, 3'd2, 64'h22, 1'b0, 1'b0);
      checkOutput("ooo_ready_after_t2", 64'(head_ready), 64'd0);
      stepCycle();
      applyStimulus(1'b0, 5'd0, 1'b1, 3'd1, 64'h11, 1'b0, 1'b0);
      checkOutput("ooo_ready_after_t1", 64'(head_ready), 64'd0);
      stepCycle();
      applyStimulus(1'b0, 5'd0, 1'b1, 3'd0, 64'h00, 1'b0, 1'b0);
      checkOutput("ooo_ready_same_cycle", 64'(head_ready), 64'(BYP));
      stepCycle();
      idle();
      checkOutput("ooo_ready_after_t0", 64'(head_ready), 64'd1);
      drainVals[0] = 64'h00;
      drainVals[1] = 64'h11;
      drainVals[2] = 64'h22;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 5'd0, 1'b0, '0, 64'd0, 1'b1, 1'b0);
         checkOutput("drain_ready", 64'(head_ready), 64'd1);
         checkOutput("drain_value", head_entry.value, drainVals[i]);
         checkOutput("drain_reg", 64'(head_entry.dest_reg), 64'(i + 1));
         stepCycle();
      end
      idle();
      checkOutput("drain_empty", 64'(rob_empty), 64'd1);
      checkOutput("drain_head_valid", 64'(head_entry.valid), 64'd0);

      // ---------------- Wrap-around steady state ----------------
      // Iteration n dispatches entry n, completes entry n-1, retires entry n-2.
      tailModel = 3'd3;
      for (int n = 0; n < 22; n++) begin
         tagOf[n] = tailModel;
         applyStimulus(1'b1, 5'(n), (n >= 1), (n >= 1) ? tagOf[(n >= 1) ? n - 1 : 0] : 3'd0,
                       64'h100 + 64'(n - 1), (n >= 2), 1'b0);
         checkOutput("wrap_tag", 64'(dispatch_tag), 64'(tailModel));
         if (n >= 2) begin
            checkOutput("wrap_count", 64'(rob_count), 64'd2);
            checkOutput("wrap_ready", 64'(head_ready), 64'd1);
            checkOutput("wrap_value", head_entry.value, 64'h100 + 64'(n - 2));
            checkOutput("wrap_reg", 64'(head_entry.dest_reg), 64'(n - 2));
         end
         stepCycle();
         tailModel = tailModel + 1'b1;
      end
      idle();
      checkOutput("wrap_end_count", 64'(rob_count), 64'd2);
      checkOutput("wrap_end_tail", 64'(dispatch_tag), 64'd1);

      // ---------------- Flush with everything asserted ----------------
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 5'(i + 30), 1'b0, '0, 64'd0, 1'b0, 1'b0);
         stepCycle();
      end
      idle();
      checkOutput("preflush_count", 64'(rob_count), 64'd5);
      applyStimulus(1'b1, 5'd7, 1'b1, tagOf[21], 64'h55, 1'b1, 1'b1);
      stepCycle();
      idle();
      checkOutput("flush_count", 64'(rob_count), 64'd0);
      checkOutput("flush_empty", 64'(rob_empty), 64'd1);
      checkOutput("flush_tag", 64'(dispatch_tag), 64'd0);
      checkOutput("flush_head_valid", 64'(head_entry.valid), 64'd0);
      checkOutput("flush_head_ready", 64'(head_ready), 64'd0);
      applyStimulus(1'b1, 5'd12, 1'b0, '0, 64'd0, 1'b0, 1'b0);
      checkOutput("postflush_tag", 64'(dispatch_tag), 64'd0);
      stepCycle();
      idle();
      checkOutput("postflush_count", 64'(rob_count), 64'd1);

      // ---------------- Head CDB + retire in the same cycle ----------------
      applyStimulus(1'b0, 5'd0, 1'b1, 3'd0, 64'hABCD, 1'b1, 1'b0);
      checkOutput("byp_ready", 64'(head_ready), 64'(BYP));
`ifdef ROB_HEAD_BYPASS_EN
      checkOutput("byp_value", head_entry.value, 64'hABCD);
`endif
      stepCycle();
      idle();
      checkOutput("byp_count", 64'(rob_count), BYP ? 64'd0 : 64'd1);
`ifndef ROB_HEAD_BYPASS_EN
      applyStimulus(1'b0, 5'd0, 1'b0, '0, 64'd0, 1'b1, 1'b0);
      checkOutput("late_ready", 64'(head_ready), 64'd1);
      checkOutput("late_value", head_entry.value, 64'hABCD);
      stepCycle();
      idle();
`endif
      checkOutput("final_empty", 64'(rob_empty), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer feeding the commit stage. Allocates one entry per cycle at dispatch, marks entries complete from the CDB, and presents the oldest entry and its readiness to commit. Entries retire strictly in program order, and the buffer is emptied on flush.

## Interface
- ROB_SIZE, default 8: number of entries; power of two, ≥2.
- TAG_W, default $clog2(ROB_SIZE): width of entry tags and pointers.
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-high; clears all state.
- dispatch_valid  in  1  request to allocate an entry at the tail.
- dispatch_entry  in  ROB_ENTRY  new entry (dest_reg, dest_addr); its value and ready fields are ignored.
- dispatch_tag  out  TAG_W  tail index; the tag given to the instruction dispatched this cycle.
- rob_full  out  1  count == ROB_SIZE.
- rob_empty  out  1  count == 0.
- rob_count  out  TAG_W+1  number of occupied entries.
- cdb_valid  in  1  completion broadcast.
- cdb_tag  in  TAG_W  entry completed.
- cdb_value  in  64  result written to entry value.
- retire  in  1  commit consumed head_entry this cycle.
- flush  in  1  discard all entries (mispredict/exception).
- head_entry  out  ROB_ENTRY  entry at head pointer.
- head_ready  out  1  head entry is valid and complete.

## Operation
- State: ROB_SIZE × ROB_ENTRY array with a valid bit and a ready bit per entry, plus head pointer, tail pointer and count. Pointers wrap modulo ROB_SIZE.
- Dispatch is accepted iff dispatch_valid && !rob_full, where rob_full is the registered value.
  - On accept: entry[tail] gets dispatch_entry, valid=1, ready=0, value=0. tail advances by 1.
  - Dispatch while full is dropped silently. A retire in the same cycle does not free space for it.
- Completion: if cdb_valid && entry[cdb_tag].valid, then entry[cdb_tag] gets value=cdb_value and ready=1. A CDB write to an invalid entry is ignored.
- Retire is accepted iff retire && head_ready.
  - On accept: entry[head] is cleared to all-zero and head advances by 1.
  - Retire without head_ready is ignored.
- Count update: count += dispatch_accepted − retire_accepted. Simultaneous dispatch and retire leaves count unchanged.
- Flush has highest priority.
  - Next cycle: all valid and ready bits are 0, head = tail = 0, count = 0.
  - Same-cycle dispatch, CDB and retire are discarded.
- head_entry is a combinational read of entry[head]. When the buffer is empty, head_entry.valid = 0.
- head_ready = entry[head].valid && entry[head].ready.

## Timing
- Reset values:
  - All entries zero; head = tail = count = 0.
  - dispatch_tag = 0, rob_empty = 1, rob_full = 0, rob_count = 0.
  - head_entry all-zero, head_ready = 0.
- Dispatch accepted at edge k into an empty ROB: head_entry.valid = 1 from cycle k+1.
- CDB at edge k: ready is visible from cycle k+1 (base build).
- Retire at edge k: the next entry is on head_entry from cycle k+1.
- Back-to-back throughput: one dispatch, one CDB and one retire per cycle.
- Wrap-around: tail and head step from ROB_SIZE−1 to 0 with no bubble.
- Reset asserted mid-operation clears state immediately, independent of clock.

## Configuration
- ROB_HEAD_BYPASS_EN
  - Defined: when cdb_valid && cdb_tag == head && entry[head].valid, the CDB write bypasses the array in the same cycle.
    - head_ready = 1 and head_entry.value = cdb_value combinationally.
    - A retire that cycle is accepted.
    - This saves one cycle of commit latency.
  - Undefined: no bypass; completion is visible one cycle after the CDB edge.

## Structure
- ROB_ENTRY typedef (valid, ready, value[63:0], dest_reg, dest_addr) and ZERO_REG live in the shared sys_defs package, common with the commit stage.
- No sub-module is needed. Pointer and count logic sit in one always_ff with asynchronous reset; read and bypass logic is combinational in the same module.

## Test plan
- Reset: assert reset mid-cycle with 3 entries held → rob_empty = 1, rob_count = 0, head_entry.valid = 0 and dispatch_tag = 0 immediately.
- Fill: 8 consecutive dispatches → tags 0..7, then rob_full = 1. A 9th dispatch is dropped; rob_count stays 8 and tail stays 0.
- Out-of-order completion:
  - Dispatch 3 entries, CDB tags 2 then 1 then 0 with values 0x22, 0x11, 0x00.
  - head_ready rises only after tag 0 completes.
  - Retiring every cycle drains values 0x00, 0x11, 0x22 in order.
- Wrap-around: steady dispatch + CDB + retire for 20 cycles → tags cycle 0..7 repeatedly, rob_count constant, no lost or duplicated retire.
- Flush: with 5 entries, assert flush together with dispatch_valid, cdb_valid and retire → next cycle rob_count = 0, rob_empty = 1, and the next dispatch gets tag 0.
- Bypass: head valid but not ready; CDB to the head tag with value 0xABCD plus retire in the same cycle.
  - With ROB_HEAD_BYPASS_EN: head_ready = 1 and value 0xABCD that cycle; retire is accepted and count drops by 1.
  - Without it: retire is ignored that cycle and accepted the following cycle.
